// File: rtl/jtopl_timer_ctrl.sv
// jtopl_timer_ctrl
//   Host-facing control stage for the OPL timer pair. Decodes writes to the
//   timer registers (0x02, 0x03, 0x04, 0x08), drives the timer block's start
//   values, run enables, flag-clear pulses and flag enables, returns the status
//   byte, and generates the CSM key-on pulse from timer A overflow.
//
// Parameters
//   CSM_EN      1: CSM key-on generation present, 0: csm_keyon tied low
//
// Ports
//   clk, rst              clock, async active-high reset
//   cenop, zero           operator clock enable, frame-start marker (valid with cenop)
//   cs_n, wr_n, addr, din host bus: chip select, write strobe, port select, data
//   dout                  status byte {irq, flag_A, flag_B, 5'b0}
//   value_A, value_B      timer start values
//   load_A, load_B        timer run enables
//   clr_flag_A/B          one-cycle flag-clear pulses
//   flagen_A/B            flag enables (inverse of the mask bits)
//   flag_A, flag_B, irq_n status inputs from the timer block
//   overflow_A            timer A overflow
//   csm_keyon             CSM key-on, held for one frame
module jtopl_timer_ctrl #(
   parameter int CSM_EN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cenop,
   input  logic       zero,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [7:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic       flagen_A,
   output logic       flagen_B,
   input  logic       flag_A,
   input  logic       flag_B,
   input  logic       irq_n,
   input  logic       overflow_A,
   output logic       csm_keyon
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} csm_st_t;

   logic       wr_act, wr_l, wr_ev;
   logic [7:0] sel;
   logic       csm;

   // Only the first cycle of an asserted strobe counts as a write.
   assign wr_act = ~cs_n & ~wr_n;
   assign wr_ev  = wr_act & ~wr_l;

   // The mask bits of reg 0x04 are kept directly as their complements,
   // flagen_A/flagen_B, so the enables update in the same edge as the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_l       <= 1'b0;
         sel        <= 8'h00;
         value_A    <= 8'h00;
         value_B    <= 8'h00;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         flagen_A   <= 1'b1;
         flagen_B   <= 1'b1;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         csm        <= 1'b0;
         dout       <= 8'h00;
      end else begin
         wr_l       <= wr_act;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         dout       <= {~irq_n, flag_A, flag_B, 5'b0};
         if (wr_ev) begin
            if (!addr) begin
               sel <= din;
            end else begin
               case (sel)
                  8'h02: value_A <= din;
                  8'h03: value_B <= din;
                  8'h04: begin
                     // bit 7 is a pure flag reset; the other fields are kept
                     if (din[7]) begin
                        clr_flag_A <= 1'b1;
                        clr_flag_B <= 1'b1;
                     end else begin
                        flagen_A <= ~din[6];
                        flagen_B <= ~din[5];
                        load_B   <= din[1];
                        load_A   <= din[0];
                     end
                  end
                  8'h08: csm <= din[7];
                  default: ;
               endcase
            end
         end
      end
   end

   generate
      if (CSM_EN != 0) begin : g_csm
         csm_st_t st;
         logic    trig;

         assign trig = load_A & overflow_A & csm;

         // State only moves on frame boundaries. A trigger at the boundary
         // that ends a pulse keeps HOLD, so back-to-back frames have no gap.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               st        <= IDLE;
               csm_keyon <= 1'b0;
            end else if (cenop & zero) begin
               case (st)
                  IDLE: if (trig) begin
                     st        <= HOLD;
                     csm_keyon <= 1'b1;
                  end
                  HOLD: if (!trig) begin
                     st        <= IDLE;
                     csm_keyon <= 1'b0;
                  end
                  default: begin
                     st        <= IDLE;
                     csm_keyon <= 1'b0;
                  end
               endcase
            end
         end
      end else begin : g_no_csm
         logic unused_csm;
         assign unused_csm = ^{cenop, zero, overflow_A, csm};
         assign csm_keyon  = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
module tb_jtopl_timer_ctrl;

   logic       clk = 1'b0, rst = 1'b0;
   logic       cenop = 1'b0, zero = 1'b0, cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0;
   logic [7:0] din = 8'h00;
   logic       flag_A = 1'b0, flag_B = 1'b0, irq_n = 1'b1, overflow_A = 1'b0;

   logic [7:0] dout, value_A, value_B;
   logic       load_A, load_B, clr_flag_A, clr_flag_B, flagen_A, flagen_B, csm_keyon;
   logic [7:0] dout0, value_A0, value_B0;
   logic       load_A0, load_B0, clr_flag_A0, clr_flag_B0, flagen_A0, flagen_B0, csm_keyon0;

   always #5 clk = ~clk;

   jtopl_timer_ctrl #(.CSM_EN(1)) dut (
      .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .cs_n(cs_n), .wr_n(wr_n),
      .addr(addr), .din(din), .dout(dout), .value_A(value_A), .value_B(value_B),
      .load_A(load_A), .load_B(load_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
      .flagen_A(flagen_A), .flagen_B(flagen_B), .flag_A(flag_A), .flag_B(flag_B),
      .irq_n(irq_n), .overflow_A(overflow_A), .csm_keyon(csm_keyon));

   jtopl_timer_ctrl #(.CSM_EN(0)) dut0 (
      .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .cs_n(cs_n), .wr_n(wr_n),
      .addr(addr), .din(din), .dout(dout0), .value_A(value_A0), .value_B(value_B0),
      .load_A(load_A0), .load_B(load_B0), .clr_flag_A(clr_flag_A0), .clr_flag_B(clr_flag_B0),
      .flagen_A(flagen_A0), .flagen_B(flagen_B0), .flag_A(flag_A), .flag_B(flag_B),
      .irq_n(irq_n), .overflow_A(overflow_A), .csm_keyon(csm_keyon0));

   int nchk = 0, nerr = 0;

   // reference model: register contents as seen in the current cycle
   logic [7:0] m_sel, m_va, m_vb, m_dout;
   logic       m_la, m_lb, m_ma, m_mb, m_csm, m_clr, m_wrl;
   // key-on equals the trigger condition seen at the most recent frame boundary
   logic       m_key;

   logic [7:0] sel_list [5] = '{8'h02, 8'h03, 8'h04, 8'h08, 8'h05};

   typedef struct {
      logic       a;
      logic [7:0] d;
      logic [7:0] va, vb;
      logic       la, lb, fa, fb, clr;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sel = 0; m_va = 0; m_vb = 0; m_dout = 0;
      m_la = 0; m_lb = 0; m_ma = 0; m_mb = 0; m_csm = 0; m_clr = 0; m_wrl = 0; m_key = 0;
   endtask

   // Called just after a rising edge with this cycle's inputs applied:
   // checks outputs mid-cycle, then advances the model over the next edge.
   task automatic tick();
      logic wa, ev;
      if (rst) model_reset();
      @(negedge clk);
      chk("value_A", value_A, m_va);
      chk("value_B", value_B, m_vb);
      chk("load", {load_A, load_B}, {m_la, m_lb});
      chk("flagen", {flagen_A, flagen_B}, {~m_ma, ~m_mb});
      chk("clr_flag", {clr_flag_A, clr_flag_B}, {m_clr, m_clr});
      chk("dout", dout, m_dout);
      chk("csm_keyon", csm_keyon, m_key);
      chk("csm_keyon_disabled", csm_keyon0, 0);
      if (rst) begin
         model_reset();
      end else begin
         wa    = !cs_n && !wr_n;
         ev    = wa && !m_wrl;
         m_wrl = wa;
         if (cenop && zero) m_key = m_la && overflow_A && m_csm;
         m_clr  = 1'b0;
         m_dout = {!irq_n, flag_A, flag_B, 5'b0};
         if (ev) begin
            if (!addr) m_sel = din;
            else if (m_sel == 8'h02) m_va = din;
            else if (m_sel == 8'h03) m_vb = din;
            else if (m_sel == 8'h04) begin
               if (din[7]) m_clr = 1'b1;
               else begin
                  m_ma = din[6]; m_mb = din[5]; m_lb = din[1]; m_la = din[0];
               end
            end else if (m_sel == 8'h08) m_csm = din[7];
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      cs_n = 0; wr_n = 0; addr = a; din = d;
      tick();
      cs_n = 1; wr_n = 1;
   endtask

   // Runs nf frames of 4 cycles, overflow at frame f's boundary when ovf[f].
   task automatic frames(input int nf, input logic [7:0] ovf, output int hi,
                         output int first, output int last);
      int n = 0;
      hi = 0; first = -1; last = -1;
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < 4; k++) begin
            cenop = 1; zero = (k == 0); overflow_A = (k == 0) && ovf[f];
            tick();
            if (csm_keyon) begin
               hi++;
               if (first < 0) first = n;
               last = n;
            end
            n++;
         end
      end
      cenop = 0; zero = 0; overflow_A = 0;
   endtask

   initial begin
      vec_t tbl [10];
      int   npulse, hi, first, last;

      tbl[0] = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 8'hC5, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 8'h03, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'h7F, 8'hC5, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 8'h05, 8'hC5, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 8'hFF, 8'hC5, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h04, 8'hC5, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 8'h43, 8'hC5, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 8'h80, 8'hC5, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[9] = '{1'b1, 8'h21, 8'hC5, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

      model_reset();
      #2 rst = 1;
      @(posedge clk); #1;
      tick(); tick();
      rst = 0;
      tick();

      // register write table
      for (int i = 0; i < 10; i++) begin
         wr(tbl[i].a, tbl[i].d);
         chk($sformatf("table[%0d]", i),
             {value_A, value_B, load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B},
             {tbl[i].va, tbl[i].vb, tbl[i].la, tbl[i].lb, tbl[i].fa, tbl[i].fb, tbl[i].clr, tbl[i].clr});
         tick();
      end

      // held strobe on 0x04/0x80: one clear pulse only
      npulse = 0;
      cs_n = 0; wr_n = 0; addr = 1; din = 8'h80;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (clr_flag_A) npulse++;
      end
      cs_n = 1; wr_n = 1;
      tick();
      if (clr_flag_A) npulse++;
      chk("held_strobe_pulses", npulse, 1);
      chk("held_strobe_load", {load_A, load_B}, 2'b10);

      // status byte and side-effect-free read
      flag_A = 1; flag_B = 0; irq_n = 0;
      tick();
      chk("dout_status", dout, 8'hC0);
      cs_n = 0; wr_n = 1; addr = 1;
      tick();
      chk("read_no_clr", {clr_flag_A, clr_flag_B}, 2'b00);
      cs_n = 1; flag_A = 0;
      tick();

      // CSM: one frame, then back-to-back frames
      wr(0, 8'h08); tick();
      wr(1, 8'h80); tick();
      frames(3, 8'b001, hi, first, last);
      chk("csm_one_frame_len", hi, 4);
      chk("csm_one_frame_start", first, 0);
      frames(3, 8'b011, hi, first, last);
      chk("csm_two_frame_len", hi, 8);
      chk("csm_two_frame_nogap", last - first + 1, 8);

      // async reset in the middle of a pulse
      cenop = 1; zero = 1; overflow_A = 1;
      tick();
      cenop = 0; zero = 0; overflow_A = 0;
      tick();
      chk("csm_hold_before_rst", csm_keyon, 1);
      rst = 1;
      #1;
      chk("rst_async_regs",
          {value_A, value_B, load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B},
          {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      chk("rst_async_dout", dout, 8'h00);
      chk("rst_async_keyon", csm_keyon, 0);
      tick();
      rst = 0;
      irq_n = 1;
      tick();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst        = (i == 300);
         cs_n       = 1'($urandom_range(0, 1));
         wr_n       = 1'($urandom_range(0, 1));
         addr       = 1'($urandom_range(0, 1));
         din        = addr ? 8'($urandom) : sel_list[$urandom_range(0, 4)];
         cenop      = 1'($urandom_range(0, 1));
         zero       = cenop & ($urandom_range(0, 2) == 0);
         overflow_A = ($urandom_range(0, 2) == 0);
         flag_A     = 1'($urandom_range(0, 1));
         flag_B     = 1'($urandom_range(0, 1));
         irq_n      = 1'($urandom_range(0, 1));
         tick();
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/jtopl_timer_ctrl.md
# jtopl_timer_ctrl

CPU-facing control stage for the OPL timer pair: decodes host writes to timer registers 0x02, 0x03, 0x04 and 0x08, and drives the timer block's value, load, flag-clear and flag-enable inputs. It returns the status byte built from the timer flags and IRQ. It also generates the CSM (composite sine mode) key-on pulse from timer A overflow for the downstream envelope stage.

## Interface
Parameters:
- CSM_EN, default 1: 1 includes CSM key-on generation; 0 ties csm_keyon low.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cenop  in  1  operator clock enable
- zero  in  1  frame-start marker; it is valid only when cenop is high
- cs_n  in  1  chip select, active-low, synchronous to clk
- wr_n  in  1  write strobe, active-low
- addr  in  1  0 selects the address port, 1 selects the data port
- din  in  8  host write data
- dout  out  8  status byte: {irq, flag_A, flag_B, 5'b0}
- value_A  out  8  timer A start value (reg 0x02)
- value_B  out  8  timer B start value (reg 0x03)
- load_A, load_B  out  1  timer run enables (reg 0x04 bits 0 and 1)
- clr_flag_A, clr_flag_B  out  1  one-cycle flag-clear pulses
- flagen_A, flagen_B  out  1  flag enables; each is the inverse of its mask bit (reg 0x04 bits 6 and 5)
- flag_A, flag_B, irq_n  in  1  status inputs returned from the timer block
- overflow_A  in  1  timer A overflow
- csm_keyon  out  1  CSM key-on, held for one frame

## Operation
- Write event: wr_act = ~cs_n & ~wr_n. A write event is the first clk cycle in which wr_act is high, detected against a registered copy of wr_act. Holding the strobe low does not repeat the write.
- Write with addr=0: sel <= din. The address is held until the next address write.
- Write with addr=1, decoded on sel:
  - 0x02: value_A <= din.
  - 0x03: value_B <= din.
  - 0x04 with din[7]=1: pulse clr_flag_A and clr_flag_B high for exactly one clk. mask_A, mask_B, load_A and load_B are unchanged.
  - 0x04 with din[7]=0: mask_A <= din[6], mask_B <= din[5], load_B <= din[1], load_A <= din[0]. No clear pulse.
  - 0x08: csm <= din[7]. The other bits are ignored here.
  - Any other sel: no effect.
- flagen_A = ~mask_A and flagen_B = ~mask_B. Both are registered.
- Status:
  - dout is registered every clk as {~irq_n, flag_A, flag_B, 5'b0}.
  - Reads (cs_n=0, wr_n=1) have no side effects.
- CSM key-on (CSM_EN=1), two states:
  - IDLE -> HOLD when cenop & zero & load_A & overflow_A & csm. csm_keyon goes high on the next clk.
  - HOLD -> IDLE at the next cenop & zero. csm_keyon goes low on the following clk.
  - An overflow at that same boundary keeps the block in HOLD, so csm_keyon stays high with no gap.
  - Clearing csm while in HOLD does not shorten the current pulse.
  - Clearing load_A blocks new triggers only.
- Reset (async, at any time, including mid-pulse or mid-HOLD):
  - sel, value_A, value_B, load_A, load_B, mask_A, mask_B, csm = 0.
  - flagen_A = flagen_B = 1.
  - clr_flag_A = clr_flag_B = 0, csm_keyon = 0, dout = 0.
  - CSM state machine = IDLE, registered wr_act = 0.
  - Release is synchronous to the next clk edge.

## Timing
- Write event at cycle N: all affected outputs change at the edge ending N and are visible in cycle N+1.
- clr_flag_* is high in cycle N+1 only.
- Back-to-back writes need wr_act to deassert for at least 1 clk between events.
- A data write in the same cycle as an address write is not possible: there is a single addr line.
- dout lags flag_A, flag_B and irq_n by 1 clk.
- CSM: the trigger is sampled at a cenop&zero cycle T, and csm_keyon is high from T+1 through the next cenop&zero cycle T' inclusive. This is one frame.
- load_A and the timer restart: a rising load_A is produced at N+1, so the timer reloads its counter at N+2.

## Test plan
- Reset values: assert rst mid-operation -> all outputs at their reset values immediately (async). flagen_A = flagen_B = 1, dout = 0x00.
- Register writes:
  - Write addr0=0x02 then addr1=0xC5 -> value_A = 0xC5 at N+1.
  - Write 0x03/0x7F -> value_B = 0x7F, value_A unchanged.
  - Write to reg 0x05 -> no output changes.
- Reg 0x04 paths:
  - Write 0x43 -> load_A = 1, load_B = 1, flagen_A = 0, flagen_B = 1.
  - Then write 0x80 -> clr_flag_A and clr_flag_B each high for exactly 1 clk, load_A and load_B still 1, masks unchanged.
- Held strobe: keep cs_n = wr_n = 0 for 10 clk with 0x04/0x80 -> exactly one clear pulse.
- Status: drive flag_A = 1, flag_B = 0, irq_n = 0 -> dout = 0xC0 one clk later. A read cycle causes no clear pulse.
- CSM:
  - Set reg 0x08 = 0x80 and load_A = 1, then pulse overflow_A on a cenop&zero cycle -> csm_keyon high for exactly one frame.
  - Overflow again at the frame boundary -> no gap.
  - With CSM_EN = 0 -> csm_keyon stays 0.
